// File: rtl/weight_sched_pkg.sv
// Shared FSM state type and default sizing for the weight-row scheduler.
package weight_sched_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_ROWS = 10;
    localparam int DEF_ROW_W    = 784;
    localparam int DEF_SCORE_W  = 10;
    localparam int DEF_CLASS_W  = 4;
endpackage

// File: rtl/weight_row_scheduler_xnor_popcount.sv
// Combinational agreement count between two bit vectors: popcount(~(a ^ b)).
module xnor_popcount
    import weight_sched_pkg::*;
#(
    parameter int ROW_W   = DEF_ROW_W,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic [ROW_W-1:0]   a,
    input  logic [ROW_W-1:0]   b,
    output logic [SCORE_W-1:0] count
);
    logic [ROW_W-1:0] eq;

    assign eq = ~(a ^ b);

    always_comb begin
        count = '0;
        for (int i = 0; i < ROW_W; i++) count = count + SCORE_W'(eq[i]);
    end
endmodule

// File: rtl/weight_row_scheduler.sv
// Streams weight rows from the ROM, scores each against the latched image and
// returns the argmax. Optional WEIGHT_SCHED_MARGIN_EN adds margin_o (best - second best).
module weight_row_scheduler
    import weight_sched_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int ROW_W    = DEF_ROW_W,
    parameter int ADDR_W   = 10,
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int CLASS_W  = DEF_CLASS_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               image_valid_i,
    output logic               image_ready_o,
    input  logic [ROW_W-1:0]   image_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [ROW_W-1:0]   weight_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [CLASS_W-1:0] class_o,
    output logic [SCORE_W-1:0] score_o
`ifdef WEIGHT_SCHED_MARGIN_EN
    ,
    output logic [SCORE_W-1:0] margin_o
`endif
);
    localparam logic [CLASS_W-1:0] LAST_ROW = CLASS_W'(NUM_ROWS - 1);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   image_q;
    logic [CLASS_W-1:0] addr_q;
    logic               issue_q;
    logic               vld_q;
    logic [CLASS_W-1:0] row_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [CLASS_W-1:0] best_class_q;
    logic [SCORE_W-1:0] pc;
    logic               accept;
    logic               take_best;

    xnor_popcount #(.ROW_W(ROW_W), .SCORE_W(SCORE_W)) u_pc (
        .a     (image_q),
        .b     (weight_i),
        .count (pc)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        image_ready_o  = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                image_ready_o = 1'b1;
                if (image_valid_i) state_d = RUN;
            end
            RUN:  if (vld_q && row_q == LAST_ROW) state_d = DONE;
            DONE: begin
                result_valid_o = 1'b1;
                if (result_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept     = image_ready_o & image_valid_i;
    assign rom_addr_o = (state_q == RUN) ? ADDR_W'(addr_q) : '0;
    // Row 0 always seeds best; strict compare keeps the lower index on ties.
    assign take_best  = (row_q == '0) || (pc > best_score_q);
    assign class_o    = best_class_q;
    assign score_o    = best_score_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            image_q      <= '0;
            addr_q       <= '0;
            issue_q      <= 1'b0;
            vld_q        <= 1'b0;
            row_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
        end else begin
            vld_q <= 1'b0;
            if (accept) begin
                image_q      <= image_i;
                addr_q       <= '0;
                issue_q      <= 1'b1;
                row_q        <= '0;
                best_score_q <= '0;
                best_class_q <= '0;
            end else if (state_q == RUN) begin
                // weight_i lags the address by one cycle, so tag it with the row issued.
                if (issue_q) begin
                    vld_q <= 1'b1;
                    row_q <= addr_q;
                    if (addr_q == LAST_ROW) issue_q <= 1'b0;
                    else                    addr_q  <= addr_q + 1'b1;
                end
                if (vld_q && take_best) begin
                    best_score_q <= pc;
                    best_class_q <= row_q;
                end
            end
        end
    end

`ifdef WEIGHT_SCHED_MARGIN_EN
    logic [SCORE_W-1:0] second_q, best_n, second_n;

    // A score equal to best demotes into second, giving margin 0 on ties.
    always_comb begin
        best_n   = best_score_q;
        second_n = second_q;
        if (row_q == '0) begin
            best_n   = pc;
            second_n = '0;
        end else if (pc > best_score_q) begin
            best_n   = pc;
            second_n = best_score_q;
        end else if (pc > second_q) begin
            second_n = pc;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            second_q <= '0;
            margin_o <= '0;
        end else if (accept) begin
            second_q <= '0;
            margin_o <= '0;
        end else if (state_q == RUN && vld_q) begin
            second_q <= second_n;
            margin_o <= best_n - second_n;
        end
    end
`endif
endmodule

// File: doc/weight_row_scheduler.md
Name: weight_row_scheduler

Overview:
- Sequences the binary weight-row ROM (10 rows x 784 bits, registered read, 1-cycle latency) to classify one binarized 28x28 image.
- Accepts an image over valid/ready and issues ROM addresses 0..NUM_ROWS-1 back-to-back.
- Scores each returned row as popcount(XNOR(image, row)) and tracks the argmax.
- Returns class index and best score over valid/ready.
- Sits between the image input stage and the result consumer; it is the sole owner of the ROM address port.

Parameters:
- NUM_ROWS, 10, number of weight rows / output classes.
- ROW_W, 784, bits per image and per weight row.
- ADDR_W, 10, ROM address width.
- SCORE_W, 10, score width; must satisfy 2^SCORE_W > ROW_W.
- CLASS_W, 4, class index width; must satisfy 2^CLASS_W >= NUM_ROWS.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- image_valid_i  input  1  image available.
- image_ready_o  output  1  scheduler can accept an image.
- image_i  input  ROW_W  binarized image; sampled only on handshake.
- rom_addr_o  output  ADDR_W  weight ROM row address.
- weight_i  input  ROW_W  ROM row data; corresponds to the address presented one cycle earlier.
- result_valid_o  output  1  result available.
- result_ready_i  input  1  consumer accepts result.
- class_o  output  CLASS_W  winning row index.
- score_o  output  SCORE_W  winning score.

Behaviour:
- Reset values: state IDLE, image_ready_o=1 (decoded from IDLE), rom_addr_o=0, result_valid_o=0, class_o=0, score_o=0, internal image register, counters and best registers cleared.
- FSM IDLE:
  - image_ready_o=1.
  - On image_valid_i & image_ready_o at edge E0: latch image_i, clear addr counter and best, go to RUN.
- FSM RUN:
  - rom_addr_o = addr counter. The counter increments every cycle up to NUM_ROWS-1 and does not advance past it.
  - A 1-cycle delayed issue flag and row index qualify weight_i.
  - On each qualified cycle, score = popcount(~(image_q ^ weight_i)). If the score is strictly greater than best, or this is row 0, update best score and class.
  - Ties keep the lower index.
  - After row NUM_ROWS-1 is scored, go to DONE.
- FSM DONE:
  - result_valid_o=1; class_o and score_o are registered and held stable.
  - rom_addr_o=0.
  - On result_ready_i, go to IDLE.
- Timing relative to E0:
  - Addresses 0..9 are presented in cycles 1..10.
  - Scores are evaluated in cycles 2..11.
  - result_valid_o rises in cycle 12 (NUM_ROWS+2).
- image_ready_o=0 in RUN and DONE. image_valid_i is ignored while busy, and image_i is not re-sampled.
- If result_ready_i is already high when result_valid_o rises, the handshake completes on that edge. IDLE and image_ready_o=1 follow in the next cycle; there is no same-cycle bypass.
- Reset asserted mid-RUN or mid-DONE: all outputs return to reset values immediately. The in-flight result is discarded.
- Addresses >= NUM_ROWS are never issued.
- rom_addr_o is driven zero-extended from the counter.
- Popcount is unsigned, SCORE_W wide, and cannot overflow (maximum 784).

Optional Feature:
- Macro: WEIGHT_SCHED_MARGIN_EN.
- Defined:
  - Adds output port margin_o (SCORE_W), held with class_o.
  - The block additionally tracks the second-best score. A tie with best counts as second-best.
  - margin_o = best - second_best, registered, reset 0.
- Undefined: no port and no second-best logic; behaviour is otherwise identical.

Decomposition:
- Package weight_sched_pkg contains:
  - the FSM state enum (IDLE, RUN, DONE);
  - NUM_ROWS, ROW_W, SCORE_W and CLASS_W defaults as localparams.
- Sub-module xnor_popcount: combinational, inputs a/b (ROW_W), output count (SCORE_W). It is instantiated once in the scheduler.

Test Plan:
- Bench ROM: behavioural, 1-cycle registered latency.
- Directed scenarios:
  - Image all 1s; row 7 all 1s; other rows all 0s -> class_o=7, score_o=784, result_valid_o exactly 12 cycles after accept edge; rom_addr_o sequence 0..9 in consecutive cycles.
  - Rows 2 and 5 identical with score 500; all other rows scoring below 500 -> class_o=2, score_o=500.
  - Image all 0s; all rows all 0s -> every score is 784; class_o=0, score_o=784.
  - result_ready_i held low 20 cycles in DONE, with image_valid_i=1 and a different image -> outputs stable; image_ready_o=0; next result reflects only the first image; accepted in the cycle after ready rises.
  - reset_i pulsed during RUN cycle 5 -> same-cycle result_valid_o=0, rom_addr_o=0, state IDLE; a new image then classifies correctly with 12-cycle latency.
  - With WEIGHT_SCHED_MARGIN_EN, scenario 1 -> margin_o=784. With scenario 2 -> margin_o=0.
